// File: rtl/exe_cmd_issue_unit.sv
// exe_cmd_issue_unit: ARM decode, condition gating, ID/EX register and NZCV status register
module exe_cmd_issue_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        freeze,
  input  logic        flush,
  input  logic [3:0]  alu_sr_out,
  output logic [3:0]  exe_cmd,
  output logic [3:0]  sr_in,
  output logic [3:0]  ex_rn,
  output logic [3:0]  ex_rd,
  output logic [11:0] ex_shift_operand,
  output logic        ex_imm,
  output logic        ex_wb_en,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_s,
  output logic        ex_valid
);
  logic [3:0] cond, opcode, cmd, f, sr;
  logic [1:0] mode;
  logic       sl, wb, mr, mw, br, s, def, cond_ok, issue, capture;
  logic       n, z, c, v;
  assign cond    = instr_in[31:28];
  assign mode    = instr_in[27:26];
  assign opcode  = instr_in[24:21];
  assign sl      = instr_in[20];
  assign capture = ex_valid && ex_s;
  // forward the EX-stage flags so the next instruction sees them a cycle early
  assign f       = capture ? alu_sr_out : sr;
  assign {n, z, c, v} = f;
  assign sr_in   = sr;
  always_comb begin
    cmd = 4'b0000;
    wb  = 1'b0;
    mr  = 1'b0;
    mw  = 1'b0;
    br  = 1'b0;
    s   = 1'b0;
    def = 1'b0;
    case (mode)
      2'b00: begin
        def = 1'b1;
        wb  = 1'b1;
        s   = sl;
        case (opcode)
          4'b1101: cmd = 4'b0001;
          4'b1111: cmd = 4'b1001;
          4'b0100: cmd = 4'b0010;
          4'b0101: cmd = 4'b0011;
          4'b0010: cmd = 4'b0100;
          4'b0110: cmd = 4'b0101;
          4'b0000: cmd = 4'b0110;
          4'b1100: cmd = 4'b0111;
          4'b0001: cmd = 4'b1000;
          4'b1010: begin cmd = 4'b0100; wb = 1'b0; s = 1'b1; end
          4'b1000: begin cmd = 4'b0110; wb = 1'b0; s = 1'b1; end
          default: def = 1'b0;
        endcase
      end
      2'b01: begin
        def = 1'b1;
        cmd = 4'b0010;
        mr  = sl;
        wb  = sl;
        mw  = !sl;
      end
      2'b10: begin
        def = 1'b1;
        br  = 1'b1;
      end
      default: def = 1'b0;
    endcase
  end
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z;
      4'h1: cond_ok = !z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = !c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = !n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = !v;
      4'h8: cond_ok = c && !z;
      4'h9: cond_ok = !c || z;
      4'hA: cond_ok = n == v;
      4'hB: cond_ok = n != v;
      4'hC: cond_ok = !z && (n == v);
      4'hD: cond_ok = z || (n != v);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  assign issue = instr_valid && def && cond_ok && !freeze && !flush;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr               <= 4'b0000;
      exe_cmd          <= 4'b0000;
      ex_rn            <= 4'b0000;
      ex_rd            <= 4'b0000;
      ex_shift_operand <= 12'h000;
      ex_imm           <= 1'b0;
      ex_wb_en         <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_mem_write     <= 1'b0;
      ex_branch        <= 1'b0;
      ex_s             <= 1'b0;
      ex_valid         <= 1'b0;
    end else begin
      sr               <= capture ? alu_sr_out : sr;
      exe_cmd          <= issue ? cmd : 4'b0000;
      ex_rn            <= instr_in[19:16];
      ex_rd            <= instr_in[15:12];
      ex_shift_operand <= instr_in[11:0];
      ex_imm           <= instr_in[25];
      ex_wb_en         <= issue && wb;
      ex_mem_read      <= issue && mr;
      ex_mem_write     <= issue && mw;
      ex_branch        <= issue && br;
      ex_s             <= issue && s;
      ex_valid         <= issue;
    end
  end
endmodule

// File: tb/tb_exe_cmd_issue_unit.sv
// tb_exe_cmd_issue_unit: directed vectors with hand-computed expectations
module tb_exe_cmd_issue_unit;
  logic        clk = 1'b0;
  logic        rst_n, instr_valid, freeze, flush;
  logic [31:0] instr_in;
  logic [3:0]  alu_sr_out, exe_cmd, sr_in, ex_rn, ex_rd;
  logic [11:0] ex_shift_operand;
  logic        ex_imm, ex_wb_en, ex_mem_read, ex_mem_write, ex_branch, ex_s, ex_valid;
  int          n_cmp = 0, n_bad = 0;
  exe_cmd_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .freeze(freeze), .flush(flush), .alu_sr_out(alu_sr_out), .exe_cmd(exe_cmd),
    .sr_in(sr_in), .ex_rn(ex_rn), .ex_rd(ex_rd), .ex_shift_operand(ex_shift_operand),
    .ex_imm(ex_imm), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_s(ex_s), .ex_valid(ex_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; instr_valid = 1'b1; freeze = 1'b0; flush = 1'b0;
    instr_in = 32'hE2821005; alu_sr_out = 4'b0000;
    step; step;
    check("rst exe_cmd", exe_cmd, 0);
    check("rst sr_in", sr_in, 0);
    check("rst valid", ex_valid, 0);
    check("rst wb", ex_wb_en, 0);
    check("rst fields", {ex_rn, ex_rd, ex_shift_operand, ex_imm}, 0);
    check("rst ctl", {ex_mem_read, ex_mem_write, ex_branch, ex_s}, 0);
    rst_n = 1'b1;
    step;
    check("add cmd", exe_cmd, 4'b0010);
    check("add fields", {ex_rn, ex_rd, ex_shift_operand, ex_imm}, {4'd2, 4'd1, 12'h005, 1'b1});
    check("add ctl", {ex_wb_en, ex_s, ex_valid, ex_mem_read, ex_mem_write, ex_branch}, 6'b101000);
    instr_in = 32'hE3510000;
    step;
    check("cmp cmd", exe_cmd, 4'b0100);
    check("cmp ctl", {ex_s, ex_wb_en, ex_valid}, 3'b101);
    alu_sr_out = 4'b0100; instr_in = 32'h0A000002;
    step;
    check("beq branch", {ex_branch, ex_valid, ex_wb_en}, 3'b110);
    check("beq cmd", exe_cmd, 4'b0000);
    check("beq sr_in", sr_in, 4'b0100);
    alu_sr_out = 4'b0000; instr_in = 32'h13A01001;
    step;
    check("movne bubble", {ex_valid, ex_wb_en}, 2'b00);
    check("movne sr_in", sr_in, 4'b0100);
    instr_in = 32'hE3E01000;
    step;
    check("mvn cmd", exe_cmd, 4'b1001);
    instr_in = 32'hE5921004;
    step;
    check("ldr cmd", exe_cmd, 4'b0010);
    check("ldr ctl", {ex_mem_read, ex_wb_en, ex_mem_write, ex_s}, 4'b1100);
    instr_in = 32'hE5821004;
    step;
    check("str ctl", {ex_mem_write, ex_wb_en, ex_mem_read, ex_valid}, 4'b1001);
    instr_in = 32'hEC000000;
    step;
    check("mode11 bubble", {ex_valid, exe_cmd}, 0);
    instr_in = 32'hF2821005;
    step;
    check("nv bubble", ex_valid, 0);
    instr_in = 32'hE2921005;
    step;
    check("adds ctl", {ex_valid, ex_s, exe_cmd}, {2'b11, 4'b0010});
    alu_sr_out = 4'b0011; flush = 1'b1; freeze = 1'b1; instr_in = 32'hE2821005;
    step;
    check("flush bubble", {ex_valid, ex_wb_en}, 2'b00);
    check("flush sr_in", sr_in, 4'b0011);
    flush = 1'b0; freeze = 1'b0; alu_sr_out = 4'b0000;
    step;
    check("resume add", {ex_valid, exe_cmd, ex_rd}, {1'b1, 4'b0010, 4'd1});
    check("resume sr_in", sr_in, 4'b0011);
    instr_in = 32'hA3A01001;
    step;
    check("movge bubble", ex_valid, 0);
    instr_in = 32'hE2821005; freeze = 1'b1;
    step;
    check("freeze bubble", ex_valid, 0);
    freeze = 1'b0; instr_valid = 1'b0;
    step;
    check("invalid bubble", ex_valid, 0);
    instr_valid = 1'b1;
    step;
    check("pre-reset add", ex_valid, 1);
    rst_n = 1'b0;
    step;
    check("midrst", {ex_valid, exe_cmd, sr_in}, 0);
    rst_n = 1'b1;
    step;
    check("post-reset add", {ex_valid, exe_cmd}, {1'b1, 4'b0010});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
